// File: rtl/alu_decode_exec.sv
// ALU decoder plus executor. Single-cycle add/sub/and/or/slt complete one
// cycle after accept. mul (shift-add) and divu (restoring) take one bit per
// cycle. A valid/ready handshake on the input side stalls the datapath while
// a long op is in flight.
module alu_decode_exec #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        ALUOp,
    input  logic [5:0]        Funct,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              out_valid,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic [2:0]        ALUControl,
    output logic              div_zero
);
    localparam logic [2:0] CTL_AND  = 3'b000;
    localparam logic [2:0] CTL_OR   = 3'b001;
    localparam logic [2:0] CTL_ADD  = 3'b010;
    localparam logic [2:0] CTL_SUB  = 3'b100;
    localparam logic [2:0] CTL_MUL  = 3'b101;
    localparam logic [2:0] CTL_SLT  = 3'b110;
    localparam logic [2:0] CTL_DIVU = 3'b111;

    localparam int               CNT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [2:0]        dec_ctl;
    logic              accept;
    logic              start_mul;
    logic              start_div;
    logic              div_by_zero;
    logic              last_iter;
    logic [DATA_W-1:0] fast_result;

    // Iterative datapath: work_a = multiplicand / divisor,
    // work_b = multiplier / dividend-then-quotient, acc = product / remainder.
    logic [DATA_W-1:0] work_a;
    logic [DATA_W-1:0] work_b;
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mul_sum;
    logic [DATA_W:0]   div_shift;
    logic [DATA_W:0]   div_trial;
    logic              div_ok;
    logic [DATA_W-1:0] div_rem;
    logic [DATA_W-1:0] div_quot;

    // Decode ALUOp/Funct into the 3-bit ALU control code.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        dec_ctl = CTL_ADD;
        case (ALUOp)
            2'b01: dec_ctl = CTL_SUB;
            2'b10: begin
                case (Funct)
                    6'b100000: dec_ctl = CTL_ADD;
                    6'b100010: dec_ctl = CTL_SUB;
                    6'b100100: dec_ctl = CTL_AND;
                    6'b100101: dec_ctl = CTL_OR;
                    6'b101010: dec_ctl = CTL_SLT;
                    6'b011100: dec_ctl = CTL_MUL;
                    6'b011011: dec_ctl = CTL_DIVU;
                    default:   dec_ctl = CTL_ADD;
                endcase
            end
            default: dec_ctl = CTL_ADD;
        endcase
    end

    assign accept      = in_valid && in_ready;
    assign div_by_zero = (dec_ctl == CTL_DIVU) && (src_b == '0);
    assign start_mul   = (dec_ctl == CTL_MUL);
    assign start_div   = (dec_ctl == CTL_DIVU) && (src_b != '0);
    assign last_iter   = (cnt == LAST_ITER);

    // Result of ops that complete in the accept cycle (divide by zero included).
    always_comb begin
        // NOTE: blocking (=) in combinational blocks; non-blocking (<=) only for clocked state.
        fast_result = src_a + src_b;
        case (dec_ctl)
            CTL_SUB:  fast_result = src_a - src_b;
            CTL_AND:  fast_result = src_a & src_b;
            CTL_OR:   fast_result = src_a | src_b;
            CTL_SLT:  fast_result = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            CTL_DIVU: fast_result = '1;
            default:  fast_result = src_a + src_b;
        endcase
    end

    // One shift-add multiply step and one restoring divide step.
    always_comb begin
        mul_sum   = acc + (work_b[0] ? work_a : '0);
        div_shift = {acc, work_b[DATA_W-1]};
        div_trial = div_shift - {1'b0, work_a};
        div_ok    = !div_trial[DATA_W];
        div_rem   = div_ok ? div_trial[DATA_W-1:0] : div_shift[DATA_W-1:0];
        div_quot  = {work_b[DATA_W-2:0], div_ok};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                in_ready  = 1'b1;
                out_valid = (state == S_DONE);
                if (in_valid) begin
                    if (start_mul)      state_next = S_MUL;
                    else if (start_div) state_next = S_DIV;
                    else                state_next = S_DONE;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (last_iter) state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Iterative working registers, loaded on accept and stepped in MUL/DIV.
    // NOTE: no reset here; these are only read in MUL/DIV, which is entered solely through an accept that loads them.
    always_ff @(posedge clk) begin
        if (accept) begin
            work_a <= start_mul ? src_a : src_b;
            work_b <= start_mul ? src_b : src_a;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == S_MUL) begin
            acc    <= mul_sum;
            work_a <= work_a << 1;
            work_b <= work_b >> 1;
            cnt    <= cnt + CNT_W'(1);
        end else if (state == S_DIV) begin
            acc    <= div_rem;
            work_b <= div_quot;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // Completion registers; they hold until the next completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            result     <= '0;
            zero       <= 1'b1;
            ALUControl <= CTL_ADD;
            div_zero   <= 1'b0;
        end else if (accept && !start_mul && !start_div) begin
            result     <= fast_result;
            zero       <= (fast_result == '0);
            ALUControl <= dec_ctl;
            div_zero   <= div_by_zero;
        end else if (state == S_MUL && last_iter) begin
            result     <= mul_sum;
            zero       <= (mul_sum == '0);
            ALUControl <= CTL_MUL;
            div_zero   <= 1'b0;
        end else if (state == S_DIV && last_iter) begin
            result     <= div_quot;
            zero       <= (div_quot == '0);
            ALUControl <= CTL_DIVU;
            div_zero   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_decode_exec.sv
// Scoreboard bench for alu_decode_exec: the driver pushes reference-model
// expectations (value and arrival cycle) on accept; a monitor pops and
// compares whenever out_valid is seen, and checks hold/reset otherwise.
module tb_alu_decode_exec;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   ALUOp = '0;
    logic [5:0]   Funct = '0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic [2:0]   ALUControl;
    logic         div_zero;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic [2:0]   ctl;
        logic         dz;
        int           at;   // latency from model, then absolute arrival cycle
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   busy_last = -1;
    logic was_rst;

    alu_decode_exec #(.DATA_W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .Funct(Funct), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .result(result), .zero(zero),
        .ALUControl(ALUControl), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: straight from the op table and arithmetic rules.
    function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [2:0] c;
        if (op == 2'b01) c = 3'b100;
        else if (op == 2'b10) begin
            case (fn)
                6'b100010: c = 3'b100;
                6'b100100: c = 3'b000;
                6'b100101: c = 3'b001;
                6'b101010: c = 3'b110;
                6'b011100: c = 3'b101;
                6'b011011: c = 3'b111;
                default:   c = 3'b010;
            endcase
        end else c = 3'b010;
        e.ctl = c;
        e.dz  = 1'b0;
        e.at  = 1;
        case (c)
            3'b100: e.res = a - b;
            3'b000: e.res = a & b;
            3'b001: e.res = a | b;
            3'b110: e.res = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            3'b101: begin e.res = a * b; e.at = W + 1; end
            3'b111: begin
                if (b == 0) begin e.res = '1; e.dz = 1'b1; end
                else begin e.res = a / b; e.at = W + 1; end
            end
            default: e.res = a + b;
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    // Present one op and hold it until accepted; checks in_ready each cycle.
    task automatic issue(input logic [1:0] op, input logic [5:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   waits = 0;
        bit   done = 0;
        @(negedge clk);
        ALUOp = op; Funct = fn; src_a = a; src_b = b; in_valid = 1'b1;
        while (!done) begin
            check("in_ready", 64'(in_ready), 64'(cyc > busy_last));
            if (in_ready) begin
                e = model(op, fn, a, b);
                if (e.at != 1) busy_last = cyc + W;
                e.at = cyc + e.at;
                sb.push_back(e);
                done = 1;
                @(posedge clk);
            end else if (waits > 100) begin
                total++; bad++;
                $display("FAIL accept_timeout: got in_ready=0 want 1 within 100 cycles");
                in_valid = 1'b0;
                done = 1;
            end else begin
                @(negedge clk);
                waits++;
            end
        end
    endtask

    // Deassert in_valid and scramble inputs for n cycles.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            src_a = $urandom; src_b = $urandom;
            Funct = 6'($urandom); ALUOp = 2'($urandom);
        end
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return '1;
            2: return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: sample 2 time units after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            was_rst = rst;
            #2;
            if (was_rst) begin
                check("rst_in_ready",  64'(in_ready),   64'(1));
                check("rst_out_valid", 64'(out_valid),  64'(0));
                check("rst_result",    64'(result),     64'(0));
                check("rst_zero",      64'(zero),       64'(1));
                check("rst_ctl",       64'(ALUControl), 64'(3'b010));
                check("rst_div_zero",  64'(div_zero),   64'(0));
                last = '{res: '0, z: 1'b1, ctl: 3'b010, dz: 1'b0, at: 0};
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out_valid: got result %0h want no output (cycle %0d)", result, cyc);
                end else begin
                    last = sb.pop_front();
                    check("result",   64'(result),     64'(last.res));
                    check("zero",     64'(zero),       64'(last.z));
                    check("ctl",      64'(ALUControl), 64'(last.ctl));
                    check("div_zero", 64'(div_zero),   64'(last.dz));
                    check("arrival_cycle", 64'(cyc),   64'(last.at));
                end
            end else begin
                check("hold", 64'({result, zero, ALUControl, div_zero}),
                      64'({last.res, last.z, last.ctl, last.dz}));
            end
        end
    end

    logic [5:0] fns [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                           6'b101010, 6'b011100, 6'b011011, 6'b000111};

    initial begin
        int k;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        issue(2'b10, 6'b100000, 7, 5);
        idle(1);
        issue(2'b01, 6'b000000, 9, 9);
        issue(2'b10, 6'b101010, '1, 1);
        idle(2);
        issue(2'b10, 6'b011100, 1234, 5678);
        idle(1);
        issue(2'b10, 6'b011011, 100, 7);
        issue(2'b10, 6'b011011, 5, 0);
        idle(1);

        // Back-to-back: add presented during a mul is taken on its DONE cycle.
        issue(2'b10, 6'b011100, $urandom, $urandom);
        issue(2'b00, 6'b000000, $urandom, $urandom);
        idle(2);

        // Full throughput of single-cycle ops.
        for (int i = 0; i < 4; i++) issue(2'b11, 6'($urandom), $urandom, $urandom);
        idle(1);

        // Reset in the middle of a multiply aborts it.
        issue(2'b10, 6'b011100, 1234, 5678);
        idle(9);
        rst = 1'b1;
        sb.delete();
        busy_last = -1;
        @(negedge clk);
        rst = 1'b0;
        idle(40);

        // Randomized ops with random gaps.
        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            logic [5:0] fn;
            op = ($urandom_range(0, 9) < 7) ? 2'b10 : 2'($urandom);
            fn = fns[$urandom_range(0, 7)];
            issue(op, fn, rand_operand(), rand_operand());
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(2);

        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: got %0d pending results want 0", sb.size());
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
